turn_input_cond: RTL

Input conditioner sitting directly upstream of the tail-light sequencer FSM. Synchronizes and debounces the raw left/right turn switches. Aligns near-simultaneous presses into a single hazard (both) request, then drives the sequencer's `l` and `r` inputs as clean levels. Also generates a one-cycle step enable `tick` so the sequencer can advance at a visible rate.

---
 rtl/turn_input_cond.sv | 134 +++++++++++++
 1 files changed

// File: rtl/turn_input_cond.sv
// Conditions the raw turn switches for the tail-light sequencer: sync, debounce,
// pair near-simultaneous presses into a hazard request, plus a step-enable tick.

module turn_db #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic s,
   output logic db
);
   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic [CW-1:0] cnt;

   // The level only moves after DB_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         db  <= 1'b0;
         cnt <= '0;
      end else if (s != db) begin
         if (cnt == CW'(DB_CYCLES - 1)) begin
            db  <= ~db;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end else begin
         cnt <= '0;
      end
   end
endmodule

module turn_input_cond #(
   parameter int DB_CYCLES = 4,
   parameter int WINDOW    = 8,
   parameter int TICK_DIV  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic left_raw,
   input  logic right_raw,
   output logic l,
   output logic r,
   output logic tick
);
   localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int KW = $clog2(TICK_DIV);

   typedef enum logic [2:0] {IDLE, WAIT_L, WAIT_R, LEFT, RIGHT, BOTH} state_t;

   // Bit 0 is the left channel, bit 1 the right channel.
   logic [1:0]    s1, s2, db;
   state_t        st, nxt;
   logic [TW-1:0] tmr, tmr_nxt;
   logic [KW-1:0] tcnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= {right_raw, left_raw};
         s2 <= s1;
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_db
      turn_db #(.DB_CYCLES(DB_CYCLES)) u_db (
         .clk  (clk),
         .reset(reset),
         .s    (s2[i]),
         .db   (db[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st  <= IDLE;
         tmr <= '0;
      end else begin
         st  <= nxt;
         tmr <= tmr_nxt;
      end
   end

   // The other channel's rise always wins over the own channel's release.
   always_comb begin
      nxt     = st;
      tmr_nxt = '0;
      case (st)
         IDLE: begin
            if (db[0] & db[1]) nxt = BOTH;
            else if (db[0])    nxt = WAIT_L;
            else if (db[1])    nxt = WAIT_R;
         end
         WAIT_L: begin
            if (db[1])                          nxt = BOTH;
            else if (!db[0])                    nxt = IDLE;
            else if (tmr == TW'(WINDOW - 1))    nxt = LEFT;
            else                                tmr_nxt = tmr + TW'(1);
         end
         WAIT_R: begin
            if (db[0])                          nxt = BOTH;
            else if (!db[1])                    nxt = IDLE;
            else if (tmr == TW'(WINDOW - 1))    nxt = RIGHT;
            else                                tmr_nxt = tmr + TW'(1);
         end
         LEFT: begin
            if (db[1])       nxt = BOTH;
            else if (!db[0]) nxt = IDLE;
         end
         RIGHT: begin
            if (db[0])       nxt = BOTH;
            else if (!db[1]) nxt = IDLE;
         end
         BOTH: begin
            if (!db[0] && !db[1]) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   assign l = (st == LEFT)  || (st == BOTH);
   assign r = (st == RIGHT) || (st == BOTH);

   always_ff @(posedge clk) begin
      if (reset)                           tcnt <= '0;
      else if (tcnt == KW'(TICK_DIV - 1))  tcnt <= '0;
      else                                 tcnt <= tcnt + KW'(1);
   end

   assign tick = (tcnt == KW'(TICK_DIV - 1));
endmodule
